// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer
//   Pops words from a show-ahead FIFO and emits each one as WORD_W/BYTE_W
//   bytes on a valid/ready byte stream. With out_ready held high, words
//   stream back to back: the next word is popped on the same cycle that the
//   last byte of the current word is accepted.
//
// Handshake (byte stream): a byte moves when out_valid && out_ready on a
// rising clk edge. While out_valid is high and out_ready is low, out_data,
// out_last and the internal position all hold. Once out_valid rises, it stays
// high until the last byte of the word is accepted; only reset can drop it
// mid-word. out_ready is don't-care while out_valid is low.
//
// FIFO side: fifo_r_en is a combinational one-cycle pop strobe. It is never
// raised while fifo_empty is high or while reset is high, and it is raised
// at most once per word.
//
// The FSM state is visible on busy (high exactly in SEND).

module fifo_byte_serializer #(
  parameter int WORD_W    = 40,
  parameter int BYTE_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_data,
  output logic              fifo_r_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int NB    = WORD_W / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic                out_valid_q, out_valid_d;
  logic [BYTE_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    words_sent_q, words_sent_d;

  logic                accept;
  logic                last_accept;
  logic                pop;

  // Byte presented first from a word (and from each shifted remainder).
  function automatic logic [BYTE_W-1:0] head_byte(input logic [WORD_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[WORD_W-1 -: BYTE_W];
    end else begin
      return w[BYTE_W-1:0];
    end
  endfunction

  // Remainder of a word after its head byte has been sent.
  function automatic logic [WORD_W-1:0] drop_head(input logic [WORD_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return w << BYTE_W;
    end else begin
      return w >> BYTE_W;
    end
  endfunction

  // Handshake decode and the pop decision shared by both states.
  always_comb begin
    accept      = (state_q == SEND) && out_ready;
    last_accept = accept && (byte_idx_q == LAST_IDX);
    pop         = !reset && !fifo_empty &&
                  ((state_q == IDLE) || last_accept);
  end

  assign fifo_r_en = pop;

  // Next-state and next-output computation for the IDLE/SEND machine.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    out_data_d   = out_data_q;
    words_sent_d = words_sent_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d    = fifo_data;
          byte_idx_d = '0;
          out_data_d = head_byte(fifo_data);
          state_d    = SEND;
        end
      end

      SEND: begin
        if (accept) begin
          if (byte_idx_q != LAST_IDX) begin
            shift_d    = drop_head(shift_q);
            byte_idx_d = byte_idx_q + IDX_W'(1);
            out_data_d = head_byte(drop_head(shift_q));
          end else begin
            words_sent_d = words_sent_q + CNT_W'(1);
            if (pop) begin
              // Chain straight into the next word without a bubble.
              shift_d    = fifo_data;
              byte_idx_d = '0;
              out_data_d = head_byte(fifo_data);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == SEND);
    busy_d      = (state_d == SEND);
    out_last_d  = (state_d == SEND) && (byte_idx_d == LAST_IDX);
  end

  // State and registered outputs; reset discards any partially sent word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;

endmodule
